// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution, 2-bit BHT update/lookup, mispredict redirect and flush.
// Optional macro BR_STATS_EN builds the resolved-branch and mispredict counters.
// Ports:
//    clk, rst                      clock, synchronous active-high reset
//    if_pc / if_pred_taken         fetch-side BHT lookup (combinational)
//    ex_valid, ex_stall            EX instruction valid / EX frozen
//    ex_br_type, ex_pc             branch kind (1..6 real, else none), EX PC
//    ex_br_target, ex_pred_taken   taken target, prediction made at IF
//    beq_sig .. bltz_sig           ALU condition flags
//    redirect_valid, redirect_pc   one-cycle registered fetch redirect
//    flush_if_id, flush_id_ex      squash the younger pipeline registers
//    stat_branches, stat_mispredicts  resolve / mispredict counters
module branch_resolve #(
   parameter int BHT_IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic [2:0]  ex_br_type,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_br_target,
   input  logic        ex_pred_taken,
   input  logic        beq_sig,
   input  logic        bne_sig,
   input  logic        bgez_sig,
   input  logic        bgtz_sig,
   input  logic        blez_sig,
   input  logic        bltz_sig,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);
   logic [1:0]           r_bht [0:(2**BHT_IDX_W)-1];
   logic                 r_redirect;
   logic [31:0]          r_redirect_pc;
   logic [BHT_IDX_W-1:0] w_if_idx;
   logic [BHT_IDX_W-1:0] w_ex_idx;
   logic                 w_taken;
   logic                 w_resolve;
   logic                 w_mispredict;
   logic [1:0]           w_ctr;
   logic [1:0]           w_ctr_next;
   logic                 w_unused;
   assign w_if_idx = if_pc[BHT_IDX_W+1:2];
   assign w_ex_idx = ex_pc[BHT_IDX_W+1:2];
   assign w_unused = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};
   // Registered table, so a same-cycle update is not yet visible here.
   assign if_pred_taken = r_bht[w_if_idx][1];
   always_comb begin
      w_taken = (ex_br_type == 3'd1) ? beq_sig  :
                (ex_br_type == 3'd2) ? bne_sig  :
                (ex_br_type == 3'd3) ? bgez_sig :
                (ex_br_type == 3'd4) ? bgtz_sig :
                (ex_br_type == 3'd5) ? blez_sig :
                (ex_br_type == 3'd6) ? bltz_sig : 1'b0;
      // The instruction in EX during a redirect cycle is wrong-path.
      w_resolve = ex_valid && !ex_stall && !r_redirect &&
                  (ex_br_type != 3'd0) && (ex_br_type != 3'd7);
      w_mispredict = w_resolve && (w_taken != ex_pred_taken);
      w_ctr = r_bht[w_ex_idx];
      w_ctr_next = w_taken ? ((w_ctr == 2'd3) ? 2'd3 : w_ctr + 2'd1)
                           : ((w_ctr == 2'd0) ? 2'd0 : w_ctr - 2'd1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**BHT_IDX_W; i++) r_bht[i] <= 2'b01;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'h0;
      end else begin
         r_redirect <= w_mispredict;
         if (w_mispredict) r_redirect_pc <= w_taken ? ex_br_target : ex_pc + 32'd4;
         if (w_resolve) r_bht[w_ex_idx] <= w_ctr_next;
      end
   end
   assign redirect_valid = r_redirect;
   assign flush_if_id    = r_redirect;
   assign flush_id_ex    = r_redirect;
   assign redirect_pc    = r_redirect_pc;
`ifdef BR_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mp;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_br <= 32'h0;
         r_stat_mp <= 32'h0;
      end else begin
         if (w_resolve) r_stat_br <= r_stat_br + 32'd1;
         if (w_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
      end
   end
   assign stat_branches    = r_stat_br;
   assign stat_mispredicts = r_stat_mp;
`else
   assign stat_branches    = 32'h0;
   assign stat_mispredicts = 32'h0;
`endif
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the ALU branch flags (beq_sig, bne_sig, bgez_sig, bgtz_sig, blez_sig, bltz_sig).
- Selects the flag for the branch type in EX, compares it with the IF-time prediction, and updates a 2-bit BHT.
- On a mispredict, issues a one-cycle registered redirect plus IF/ID and ID/EX flush.
- Also serves the combinational BHT lookup used by IF.

Parameters:
- BHT_IDX_W, 6, BHT index width; entries = 2**BHT_IDX_W; index = pc[BHT_IDX_W+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch PC used for the lookup.
- if_pred_taken  out  1  bht[idx(if_pc)][1]; combinational.
- ex_valid  in  1  EX holds a valid instruction.
- ex_stall  in  1  EX frozen this cycle.
- ex_br_type  in  3  0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 reserved (treated as none).
- ex_pc  in  32  PC of the EX instruction.
- ex_br_target  in  32  taken target.
- ex_pred_taken  in  1  prediction carried down from IF.
- beq_sig, bne_sig, bgez_sig, bgtz_sig, blez_sig, bltz_sig  in  1 each  ALU flags.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch PC.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- stat_branches  out  32  resolved-branch count (see Optional Feature).
- stat_mispredicts  out  32  mispredict count (see Optional Feature).

Behaviour:
- Resolve condition (cycle N): resolve = ex_valid && !ex_stall && !redirect_valid && ex_br_type in 1..6.
- taken = the flag selected by ex_br_type.
- mispredict = resolve && (taken != ex_pred_taken).
- Redirect (registered, visible in cycle N+1):
  - redirect_valid = flush_if_id = flush_id_ex = mispredict, each high for exactly one cycle.
  - redirect_pc = taken ? ex_br_target : ex_pc + 32'd4 (modulo 2^32; no delay slot).
  - redirect_pc holds its last value when redirect_valid is 0.
- Self-squash: while redirect_valid is high, the EX instruction is wrong-path.
  - No resolve, no BHT update, no stats update that cycle.
  - redirect_valid therefore never asserts on two consecutive cycles.
- BHT update, on resolve, at index idx(ex_pc):
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Updates when no mispredict occurs as well.
- Lookup/update collision: a lookup at the same index in the same cycle returns the pre-update value (read-before-write).
- ex_stall high: the block holds all state. Any redirect pulse already registered still completes in its one cycle.
- Reset (synchronous, rst high at the edge):
  - every BHT counter = 2'b01 (weakly not-taken);
  - redirect_valid = 0, flush_if_id = 0, flush_id_ex = 0;
  - redirect_pc = 32'h0;
  - stat counters = 0.
  - rst overrides a same-cycle resolve; a redirect pending at the reset edge is dropped.
- Non-branch or reserved ex_br_type: no redirect, no BHT change.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - stat_branches increments by 1 on each resolve.
  - stat_mispredicts increments by 1 on each mispredict.
  - Both are 32-bit, wrap 32'hFFFFFFFF -> 0, and clear on rst.
- Undefined: no counter registers are built; both outputs are tied to 32'h0.

Test Plan:
- Reset, then if_pc=32'h00400000 -> if_pred_taken=0. All outputs 0. Every BHT entry reads 2'b01.
- beq: ex_pc=32'h00400010, target 32'h00400040, pred 0, beq_sig=1 -> next cycle redirect_valid=1, redirect_pc=32'h00400040, both flushes 1 for exactly one cycle. Entry 4 becomes 2'b10.
- bltz: ex_pc=32'h00400020, pred 1, bltz_sig=0 -> redirect_pc=32'h00400024. A valid beq with beq_sig=1 arriving in the redirect cycle is ignored: no second pulse, BHT unchanged.
- Three correctly predicted taken bne at index 4 -> counter saturates at 3, no redirect. Then one not-taken -> 2; if_pred_taken at that index is still 1.
- ex_stall=1 with a mispredicting bgez present -> no redirect, no BHT change. Release stall -> redirect on the following cycle.
- BR_STATS_EN defined, 5 branches with 2 mispredicts -> stat_branches=5, stat_mispredicts=2. rst clears both. Undefined build -> both read 0 throughout.
